// File: rtl/sma_level_detect.sv
// Debounced, hysteretic level detector for the smoothed moving-average sample.
// Produces level with rise/fall pulses, a saturating rise counter and a running peak.
module sma_level_detect #(
    parameter int                        DATA_W    = 16,
    parameter logic signed [DATA_W-1:0]  HI_THRESH = 16'sd1000,
    parameter logic signed [DATA_W-1:0]  LO_THRESH = 16'sd500,
    parameter int                        DEBOUNCE  = 4,
    parameter int                        HOLDOFF   = 8,
    parameter int                        CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] y,
    input  logic                     clr,
    output logic                     level,
    output logic                     rise_pulse,
    output logic                     fall_pulse,
    output logic [CNT_W-1:0]         event_cnt,
    output logic signed [DATA_W-1:0] peak
);

    localparam int DW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {S_LOW, S_RISING, S_HIGH, S_FALLING} state_t;

    state_t                     state, state_n;
    logic [DW-1:0]              dcnt, dcnt_n;
    logic [HW-1:0]              hcnt, hcnt_n;
    logic                       level_n, rise_n, fall_n;
    logic [CNT_W-1:0]           cnt_n;
    logic signed [DATA_W-1:0]   peak_n;
    logic                       ge_hi, le_lo;

    assign ge_hi = (y >= HI_THRESH);
    assign le_lo = (y <= LO_THRESH);

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        hcnt_n  = hcnt;
        level_n = level;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            S_LOW: begin
                if (hcnt != '0) begin
                    hcnt_n = hcnt - 1'b1;
                end else if (ge_hi) begin
                    if (DEBOUNCE == 1) begin
                        state_n = S_HIGH;
                        level_n = 1'b1;
                        rise_n  = 1'b1;
                        hcnt_n  = HW'(HOLDOFF);
                    end else begin
                        state_n = S_RISING;
                        dcnt_n  = DW'(1);
                    end
                end
            end
            S_RISING: begin
                if (ge_hi) begin
                    if (dcnt == DW'(DEBOUNCE - 1)) begin
                        state_n = S_HIGH;
                        level_n = 1'b1;
                        rise_n  = 1'b1;
                        dcnt_n  = '0;
                        hcnt_n  = HW'(HOLDOFF);
                    end else begin
                        dcnt_n = dcnt + 1'b1;
                    end
                end else begin
                    state_n = S_LOW;
                    dcnt_n  = '0;
                end
            end
            S_HIGH: begin
                if (hcnt != '0) begin
                    hcnt_n = hcnt - 1'b1;
                end else if (le_lo) begin
                    if (DEBOUNCE == 1) begin
                        state_n = S_LOW;
                        level_n = 1'b0;
                        fall_n  = 1'b1;
                        hcnt_n  = HW'(HOLDOFF);
                    end else begin
                        state_n = S_FALLING;
                        dcnt_n  = DW'(1);
                    end
                end
            end
            default: begin
                if (le_lo) begin
                    if (dcnt == DW'(DEBOUNCE - 1)) begin
                        state_n = S_LOW;
                        level_n = 1'b0;
                        fall_n  = 1'b1;
                        dcnt_n  = '0;
                        hcnt_n  = HW'(HOLDOFF);
                    end else begin
                        dcnt_n = dcnt + 1'b1;
                    end
                end else begin
                    state_n = S_HIGH;
                    dcnt_n  = '0;
                end
            end
        endcase
    end

    // clr wins over the old count, but a coincident rise still counts as the first event
    always_comb begin
        cnt_n = event_cnt;
        if (clr)
            cnt_n = rise_n ? CNT_W'(1) : '0;
        else if (rise_n && (event_cnt != '1))
            cnt_n = event_cnt + 1'b1;
        peak_n = peak;
        if (clr)
            peak_n = y;
        else if (y > peak)
            peak_n = y;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_LOW;
            dcnt       <= '0;
            hcnt       <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            event_cnt  <= '0;
            peak       <= {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            state      <= state_n;
            dcnt       <= dcnt_n;
            hcnt       <= hcnt_n;
            level      <= level_n;
            rise_pulse <= rise_n;
            fall_pulse <= fall_n;
            event_cnt  <= cnt_n;
            peak       <= peak_n;
        end
    end

endmodule

// File: tb/tb_sma_level_detect.sv
// Bench for sma_level_detect: table vectors, directed corner sequences and
// randomized stimulus against a run-length reference model; three configurations.
module tb_sma_level_detect;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    logic signed [15:0] y = '0;

    logic level_a, rise_a, fall_a;
    logic [15:0] cnt_a;
    logic signed [15:0] peak_a;
    logic level_b, rise_b, fall_b;
    logic [1:0] cnt_b;
    logic signed [15:0] peak_b;
    logic level_c, rise_c, fall_c;
    logic [15:0] cnt_c;
    logic signed [15:0] peak_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sma_level_detect dut_a (
        .clk(clk), .rst(rst), .y(y), .clr(clr), .level(level_a), .rise_pulse(rise_a),
        .fall_pulse(fall_a), .event_cnt(cnt_a), .peak(peak_a));

    sma_level_detect #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .y(y), .clr(clr), .level(level_b), .rise_pulse(rise_b),
        .fall_pulse(fall_b), .event_cnt(cnt_b), .peak(peak_b));

    sma_level_detect #(.HI_THRESH(16'sd1000), .LO_THRESH(16'sd1000), .DEBOUNCE(1),
                       .HOLDOFF(0)) dut_c (
        .clk(clk), .rst(rst), .y(y), .clr(clr), .level(level_c), .rise_pulse(rise_c),
        .fall_pulse(fall_c), .event_cnt(cnt_c), .peak(peak_c));

    typedef struct {
        int level; int run; int hold; int rise; int fall; int cnt; int peak;
    } mst_t;

    mst_t ma, mb, mc;

    function automatic mst_t mreset();
        mst_t s;
        s.level = 0; s.run = 0; s.hold = 0; s.rise = 0; s.fall = 0;
        s.cnt = 0; s.peak = -32768;
        return s;
    endfunction

    // switch after `deb` consecutive qualifying samples, then ignore `hold` samples
    function automatic mst_t mstep(mst_t s, int yv, bit c, int hi, int lo, int deb,
                                   int holdv, int cmax);
        bit qual;
        s.rise = 0; s.fall = 0;
        if (s.hold > 0) begin
            s.hold--;
        end else begin
            qual = (s.level != 0) ? (yv <= lo) : (yv >= hi);
            if (qual) begin
                s.run++;
                if (s.run >= deb) begin
                    s.level = 1 - s.level;
                    s.run = 0;
                    s.hold = holdv;
                    if (s.level != 0) s.rise = 1; else s.fall = 1;
                end
            end else begin
                s.run = 0;
            end
        end
        if (c) s.cnt = s.rise;
        else if (s.rise != 0 && s.cnt < cmax) s.cnt++;
        if (c) s.peak = yv;
        else if (yv > s.peak) s.peak = yv;
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " A.level"}, int'(level_a), ma.level);
        chk({tag, " A.rise"},  int'(rise_a),  ma.rise);
        chk({tag, " A.fall"},  int'(fall_a),  ma.fall);
        chk({tag, " A.cnt"},   int'(cnt_a),   ma.cnt);
        chk({tag, " A.peak"},  int'(peak_a),  ma.peak);
        chk({tag, " B.level"}, int'(level_b), mb.level);
        chk({tag, " B.cnt"},   int'(cnt_b),   mb.cnt);
        chk({tag, " B.peak"},  int'(peak_b),  mb.peak);
        chk({tag, " C.level"}, int'(level_c), mc.level);
        chk({tag, " C.rise"},  int'(rise_c),  mc.rise);
        chk({tag, " C.fall"},  int'(fall_c),  mc.fall);
        chk({tag, " C.cnt"},   int'(cnt_c),   mc.cnt);
        chk({tag, " C.peak"},  int'(peak_c),  mc.peak);
        chk({tag, " A.excl"},  int'(rise_a & fall_a), 0);
    endtask

    task automatic step(input int yv, input bit c);
        y   = 16'(yv);
        clr = c;
        @(posedge clk);
        ma = mstep(ma, yv, c, 1000, 500, 4, 8, 65535);
        mb = mstep(mb, yv, c, 1000, 500, 4, 8, 3);
        mc = mstep(mc, yv, c, 1000, 1000, 1, 0, 65535);
        @(negedge clk);
        check_all("step");
    endtask

    task automatic steps(input int yv, input int n);
        for (int i = 0; i < n; i++) step(yv, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;
        #1;
        ma = mreset(); mb = mreset(); mc = mreset();
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    // from any LOW state: drain holdoff, then a 4-sample rise (clr optional on the last)
    task automatic rise_seq(input bit c);
        steps(0, 10);
        steps(1200, 3);
        step(1200, c);
        chk("rise_seq A.rise", int'(rise_a), 1);
    endtask

    task automatic fall_seq();
        steps(1200, 10);
        steps(400, 4);
        chk("fall_seq A.fall", int'(fall_a), 1);
    endtask

    typedef struct {
        int y; bit clr; bit level; bit rise; bit fall; int cnt; int peak;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int hold_v;
        int hold_n;

        ma = mreset(); mb = mreset(); mc = mreset();
        tbl[0]  = '{-5,     1'b0, 1'b0, 1'b0, 1'b0, 0, -5};
        tbl[1]  = '{-300,   1'b0, 1'b0, 1'b0, 1'b0, 0, -5};
        tbl[2]  = '{900,    1'b0, 1'b0, 1'b0, 1'b0, 0, 900};
        tbl[3]  = '{-32768, 1'b0, 1'b0, 1'b0, 1'b0, 0, 900};
        tbl[4]  = '{-7,     1'b1, 1'b0, 1'b0, 1'b0, 0, -7};
        tbl[5]  = '{1200,   1'b0, 1'b0, 1'b0, 1'b0, 0, 1200};
        tbl[6]  = '{1200,   1'b0, 1'b0, 1'b0, 1'b0, 0, 1200};
        tbl[7]  = '{1200,   1'b0, 1'b0, 1'b0, 1'b0, 0, 1200};
        tbl[8]  = '{1200,   1'b0, 1'b1, 1'b1, 1'b0, 1, 1200};
        tbl[9]  = '{700,    1'b0, 1'b1, 1'b0, 1'b0, 1, 1200};
        tbl[10] = '{400,    1'b1, 1'b1, 1'b0, 1'b0, 0, 400};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].y, tbl[i].clr);
            chk($sformatf("tbl[%0d] level", i), int'(level_a), int'(tbl[i].level));
            chk($sformatf("tbl[%0d] rise", i),  int'(rise_a),  int'(tbl[i].rise));
            chk($sformatf("tbl[%0d] fall", i),  int'(fall_a),  int'(tbl[i].fall));
            chk($sformatf("tbl[%0d] cnt", i),   int'(cnt_a),   tbl[i].cnt);
            chk($sformatf("tbl[%0d] peak", i),  int'(peak_a),  tbl[i].peak);
        end

        // idle at zero, then rise latency, then an aborted 3-sample arm
        do_reset();
        steps(0, 20);
        chk("t1 level", int'(level_a), 0);
        chk("t1 cnt", int'(cnt_a), 0);
        chk("t1 peak", int'(peak_a), 0);
        steps(1200, 3);
        chk("t2 no early rise", int'(rise_a), 0);
        step(1200, 1'b0);
        chk("t2 rise", int'(rise_a), 1);
        chk("t2 level", int'(level_a), 1);
        chk("t2 cnt", int'(cnt_a), 1);
        step(1200, 1'b0);
        chk("t2 pulse one cycle", int'(rise_a), 0);
        fall_seq();
        steps(0, 10);
        steps(1200, 3);
        step(0, 1'b0);
        chk("t2 aborted arm", int'(level_a), 0);
        steps(0, 5);

        // hysteresis band, then holdoff masking after a fresh rise
        rise_seq(1'b0);
        steps(700, 50);
        chk("t3 band holds", int'(level_a), 1);
        steps(400, 4);
        chk("t3 fall", int'(fall_a), 1);
        rise_seq(1'b0);
        steps(400, 8);
        chk("t3 holdoff ignores", int'(level_a), 1);
        steps(400, 3);
        chk("t3 debounce pending", int'(level_a), 1);
        step(400, 1'b0);
        chk("t3 fall after holdoff", int'(fall_a), 1);

        // saturating counter on the 2-bit instance, then clr coincident with a rise
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rise_seq(1'b0);
            chk($sformatf("t4 cnt_b rise %0d", i + 1), int'(cnt_b), (i < 3) ? i + 1 : 3);
            fall_seq();
        end
        chk("t4 cnt_a", int'(cnt_a), 5);
        rise_seq(1'b1);
        chk("t4 clr+rise cnt_b", int'(cnt_b), 1);
        chk("t4 clr+rise cnt_a", int'(cnt_a), 1);

        // async reset in the middle of a debounce run
        do_reset();
        steps(0, 10);
        steps(1200, 3);
        #2;
        rst = 1'b0;
        #1;
        ma = mreset(); mb = mreset(); mc = mreset();
        check_all("t6 async");
        chk("t6 peak reset", int'(peak_a), -32768);
        @(negedge clk);
        rst = 1'b1;
        steps(1200, 3);
        chk("t6 no rise after reset", int'(level_a), 0);
        step(1200, 1'b0);
        chk("t6 rise on fourth", int'(rise_a), 1);

        // randomized segments biased toward the threshold edges
        for (int seg = 0; seg < 400; seg++) begin
            case ($urandom_range(0, 7))
                0: hold_v = 1200;
                1: hold_v = 1000;
                2: hold_v = 999;
                3: hold_v = 500;
                4: hold_v = 501;
                5: hold_v = 0;
                6: hold_v = 700;
                default: hold_v = int'($signed(16'($urandom)));
            endcase
            hold_n = $urandom_range(1, 7);
            for (int k = 0; k < hold_n; k++)
                step(hold_v, ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
